// File: rtl/ex_div_pkg.sv
// Shared definitions for the execute-stage divider: funct3 encodings and
// the sign fix-up applied to the unsigned magnitude result.
package ex_div_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == INST_DIV) || (op == INST_REM);
    endfunction

    // Picks quotient or remainder and restores the sign lost by the magnitude path.
    function automatic logic [XLEN-1:0] div_result(input logic [2:0]      op,
                                                   input logic [XLEN-1:0] quot,
                                                   input logic [XLEN-1:0] rem,
                                                   input logic            negQuot,
                                                   input logic            negRem);
        case (op)
            INST_REM, INST_REMU: return negRem ? -rem : rem;
            INST_DIV, INST_DIVU: return negQuot ? -quot : quot;
            default:             return quot;
        endcase
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring 32-bit divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Define DIV_ZERO_FAST_EN to finish a divide-by-zero in a single cycle.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [4:0]       reg_waddr_i,
    input  logic             flush_i,
    output logic             hold_req_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       reg_waddr_o,
    output logic             reg_we_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_END  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       regWaddr_q, regWaddr_d;

    logic             signedIn;
    logic             signA, signB;
    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH:0]   stepShift, stepDiff;
    logic             stepGe;
    logic [WIDTH-1:0] remNext, quotNext;
    logic             fastZero;

`ifdef DIV_ZERO_FAST_EN
    assign fastZero = (divisor_i == '0);
`else
    assign fastZero = 1'b0;
`endif

    assign signedIn = is_signed_op(op_i);
    assign signA    = signedIn & dividend_i[WIDTH-1];
    assign signB    = signedIn & divisor_i[WIDTH-1];
    assign absA     = signA ? -dividend_i : dividend_i;
    assign absB     = signB ? -divisor_i : divisor_i;

    // The quotient bits shift into the dividend register as its bits move into rem.
    assign stepShift = {rem_q, dvd_q[WIDTH-1]};
    assign stepDiff  = stepShift - {1'b0, dvs_q};
    assign stepGe    = ~stepDiff[WIDTH];
    assign remNext   = stepGe ? stepDiff[WIDTH-1:0] : stepShift[WIDTH-1:0];
    assign quotNext  = {dvd_q[WIDTH-2:0], stepGe};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        waddr_d    = waddr_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        regWaddr_d = regWaddr_q;
        hold_req_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    hold_req_o = 1'b1;
                    op_d       = op_i;
                    waddr_d    = reg_waddr_i;
                    sa_d       = signA;
                    sb_d       = signB;
                    dvs_d      = absB;
                    dvd_d      = absA;
                    rem_d      = '0;
                    cnt_d      = 5'd31;
                    state_d    = S_CALC;
                    if (fastZero) begin
                        dvd_d      = '1;
                        rem_d      = absA;
                        result_d   = div_result(op_i, '1, absA, 1'b0, signA);
                        regWaddr_d = reg_waddr_i;
                        state_d    = S_END;
                    end
                end
            end
            S_CALC: begin
                hold_req_o = 1'b1;
                rem_d      = remNext;
                dvd_d      = quotNext;
                cnt_d      = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    result_d   = div_result(op_q, quotNext, remNext,
                                            (sa_q ^ sb_q) & (dvs_q != '0), sa_q);
                    regWaddr_d = waddr_q;
                    state_d    = S_END;
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A kill abandons the operation without touching the visible result.
        if (flush_i) begin
            state_d    = S_IDLE;
            result_d   = result_q;
            regWaddr_d = regWaddr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            waddr_q    <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            regWaddr_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            waddr_q    <= waddr_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            regWaddr_q <= regWaddr_d;
        end
    end

    assign ready_o     = (state_q == S_END);
    assign reg_we_o    = ready_o;
    assign result_o    = result_q;
    assign reg_waddr_o = regWaddr_q;

endmodule

// File: tb/tb_ex_div.sv
// Directed vector bench for ex_div; honours DIV_ZERO_FAST_EN for divide-by-zero latency.
module tb_ex_div;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FastZero = 1'b1;
`else
    localparam bit FastZero = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'b000;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic [4:0]  reg_waddr_i = '0;
    logic        flush_i = 1'b0;
    logic        hold_req_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[14];

    ex_div #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .reg_waddr_i(reg_waddr_i),
        .flush_i    (flush_i),
        .hold_req_o (hold_req_o),
        .ready_o    (ready_o),
        .result_o   (result_o),
        .reg_waddr_o(reg_waddr_o),
        .reg_we_o   (reg_we_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Called at a falling edge: starts the op in this cycle and follows it to completion.
    task automatic applyStimulus(input vec_t v, input int injectAt);
        int          lat;
        int          expLat;
        logic        holdOk;
        logic        weOk;
        logic [31:0] res;
        logic [4:0]  rd;
        lat    = 0;
        holdOk = 1'b1;
        weOk   = 1'b1;
        res    = '0;
        rd     = '0;
        expLat = (FastZero && v.b == 32'd0) ? 1 : 33;
        start_i     = 1'b1;
        op_i        = v.op;
        dividend_i  = v.a;
        divisor_i   = v.b;
        reg_waddr_i = v.rd;
        flush_i     = 1'b0;
        #1;
        checkOutput({v.name, " hold@T"}, {31'b0, hold_req_o}, 32'd1);
        @(negedge clk);
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            if (k == injectAt) begin
                start_i     = 1'b1;
                op_i        = 3'b101;
                dividend_i  = 32'h0000_0064;
                divisor_i   = 32'h0000_0003;
                reg_waddr_i = 5'd1;
            end else begin
                start_i     = 1'b0;
                dividend_i  = 32'hDEAD_BEEF;
                divisor_i   = 32'h0BAD_F00D;
                reg_waddr_i = 5'd0;
            end
            #1;
            if (hold_req_o !== (k < expLat)) holdOk = 1'b0;
            if (reg_we_o !== ready_o) weOk = 1'b0;
            if (ready_o === 1'b1) begin
                lat = k;
                res = result_o;
                rd  = reg_waddr_o;
            end
            @(negedge clk);
        end
        start_i = 1'b0;
        #1;
        checkOutput({v.name, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({v.name, " result"}, res, v.exp);
        checkOutput({v.name, " waddr"}, {27'b0, rd}, {27'b0, v.rd});
        checkOutput({v.name, " hold"}, {31'b0, holdOk}, 32'd1);
        checkOutput({v.name, " we==ready"}, {31'b0, weOk}, 32'd1);
        checkOutput({v.name, " ready pulse"}, {31'b0, ready_o}, 32'd0);
        checkOutput({v.name, " result held"}, result_o, v.exp);
    endtask

    initial begin
        logic sawReady;
        vecs[0]  = '{3'b101, 32'd100,        32'd7,          5'd3,  32'd14,         "DIVU 100/7"};
        vecs[1]  = '{3'b111, 32'd100,        32'd7,          5'd4,  32'd2,          "REMU 100/7"};
        vecs[2]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          5'd5,  32'hFFFF_FFFF,  "REM -7/2"};
        vecs[3]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFD,  "DIV -7/2"};
        vecs[4]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000,  "DIV ovf"};
        vecs[5]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h0000_0000,  "REM ovf"};
        vecs[6]  = '{3'b100, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF,  "DIV 5/0"};
        vecs[7]  = '{3'b111, 32'd5,          32'd0,          5'd10, 32'd5,          "REMU 5/0"};
        vecs[8]  = '{3'b110, 32'hFFFF_FFF9,  32'd0,          5'd11, 32'hFFFF_FFF9,  "REM -7/0"};
        vecs[9]  = '{3'b100, 32'hFFFF_FFF9,  32'd0,          5'd12, 32'hFFFF_FFFF,  "DIV -7/0"};
        vecs[10] = '{3'b100, 32'd7,          32'hFFFF_FFFE,  5'd13, 32'hFFFF_FFFD,  "DIV 7/-2"};
        vecs[11] = '{3'b110, 32'd7,          32'hFFFF_FFFE,  5'd14, 32'd1,          "REM 7/-2"};
        vecs[12] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  5'd15, 32'd0,          "DIVU big"};
        vecs[13] = '{3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  5'd31, 32'h8000_0000,  "REMU big"};

        repeat (3) @(negedge clk);
        checkOutput("reset ready", {31'b0, ready_o}, 32'd0);
        checkOutput("reset we", {31'b0, reg_we_o}, 32'd0);
        checkOutput("reset hold", {31'b0, hold_req_o}, 32'd0);
        checkOutput("reset result", result_o, 32'd0);
        checkOutput("reset waddr", {27'b0, reg_waddr_o}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], 0);
        end

        // A start presented mid-calculation must not disturb the operation.
        applyStimulus('{3'b101, 32'd1000, 32'd9, 5'd17, 32'd111, "DIVU ignore-start"}, 5);

        // Flush in T+10, then a fresh op started in T+11.
        sawReady    = 1'b0;
        start_i     = 1'b1;
        op_i        = 3'b101;
        dividend_i  = 32'd1000;
        divisor_i   = 32'd3;
        reg_waddr_i = 5'd20;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            flush_i = (k == 10);
            #1;
            if (ready_o === 1'b1) sawReady = 1'b1;
        end
        checkOutput("flush hold low", {31'b0, hold_req_o}, 32'd0);
        checkOutput("flush no ready", {31'b0, sawReady}, 32'd0);
        checkOutput("flush result kept", result_o, 32'd111);
        applyStimulus('{3'b101, 32'd1000, 32'd7, 5'd21, 32'd142, "DIVU after flush"}, 0);

        // Reset asserted in T+20 of a running divide.
        start_i     = 1'b1;
        op_i        = 3'b101;
        dividend_i  = 32'h0000_FFFF;
        divisor_i   = 32'h0000_0010;
        reg_waddr_i = 5'd22;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start_i = 1'b0;
        end
        rst = 1'b0;
        #1;
        checkOutput("rst ready", {31'b0, ready_o}, 32'd0);
        checkOutput("rst we", {31'b0, reg_we_o}, 32'd0);
        checkOutput("rst hold", {31'b0, hold_req_o}, 32'd0);
        checkOutput("rst result", result_o, 32'd0);
        checkOutput("rst waddr", {27'b0, reg_waddr_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        sawReady = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (ready_o === 1'b1 || hold_req_o === 1'b1) sawReady = 1'b1;
        end
        checkOutput("post-rst idle", {31'b0, sawReady}, 32'd0);
        @(negedge clk);
        applyStimulus('{3'b101, 32'h0000_FFFF, 32'h0000_0010, 5'd23, 32'h0000_0FFF, "DIVU after rst"}, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
